// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// Module      : muldiv_unit_pkg
// Description : Shared types and constants for the iterative multiply/divide
//               unit: operation encoding, word type, iteration count and
//               small operand helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

  // Iterations per operation; equals the word width.
  localparam int MD_STEPS = 32;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return ~op[0];
  endfunction

  // Magnitude of a two's-complement word when en is set, raw value otherwise.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic word_t abs_word(input word_t v, input logic en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_if.sv
// ============================================================================
// Module      : muldiv_unit_if
// Description : Execute-stage connection of the multiply/divide unit.
//               master : pipeline side (drives start/op/operands/flush/MTxx)
//               slave  : muldiv_unit side (drives stall/busy/done/hi/lo)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic       start;   // decoded mul/div in execute, qualified by ihit
  muldiv_op_t op;      // operation selector
  word_t      srcA;    // forwarded rs value
  word_t      srcB;    // forwarded rt value
  logic       flush;   // execute-stage flush
  logic       hi_wen;  // MTHI strobe
  logic       lo_wen;  // MTLO strobe
  word_t      wdat;    // MTHI/MTLO data
  logic       stall;   // freeze PC and pipeline latches
  logic       busy;    // FSM not idle
  logic       done;    // one-cycle pulse, HI/LO just updated
  word_t      hi;      // architectural HI
  word_t      lo;      // architectural LO

  modport master (
    output start, op, srcA, srcB, flush, hi_wen, lo_wen, wdat,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB, flush, hi_wen, lo_wen, wdat,
    output stall, busy, done, hi, lo
  );

endinterface

`default_nettype wire

// File: rtl/muldiv_unit_step.sv
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of the multiply/divide datapath.
//               Multiply : {upper, multiplier} shift-add step.
//               Divide   : {rem, quo} restoring-divide step.
// Ports       : i_is_div  - 1 selects the divide step
//               i_acc     - current 64-bit accumulator
//               i_operand - multiplicand (mult) or divisor (div)
//               o_acc     - accumulator after this step
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step (
  input  wire logic        i_is_div,
  input  wire logic [63:0] i_acc,
  input  wire logic [31:0] i_operand,
  output logic      [63:0] o_acc
);

  logic [32:0] w_sum;
  logic [33:0] w_diff;
  logic [63:0] w_shl;

  always_comb begin
    // Multiply: 33-bit sum keeps the carry, which enters bit 63 on the shift.
    w_sum = i_acc[0] ? ({1'b0, i_acc[63:32]} + {1'b0, i_operand})
                     : {1'b0, i_acc[63:32]};
    // Divide: after the left shift the partial remainder can reach 33 bits
    // (divisor above 2^31), so the trial subtract uses acc[63:31] directly.
    w_shl  = {i_acc[62:0], 1'b0};
    w_diff = {1'b0, i_acc[63:31]} - {2'b00, i_operand};

    if (!i_is_div) begin
      o_acc = {w_sum, i_acc[31:1]};
    end else if (!w_diff[33]) begin
      // Difference is below the divisor, so it fits 32 bits.
      o_acc = {w_diff[31:0], w_shl[31:1], 1'b1};
    end else begin
      o_acc = w_shl;
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Runs
//               MD_STEPS iterations of muldiv_step, applies sign fixup,
//               commits HI/LO and holds the pipeline via stall.
// Ports       : CLK, RST - clock, synchronous active-high reset
//               bus       - muldiv_unit_if.slave (start/op/srcA/srcB/flush,
//                           hi_wen/lo_wen/wdat in; stall/busy/done/hi/lo out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int MD_STEPS = muldiv_unit_pkg::MD_STEPS
) (
  input  wire logic     CLK,
  input  wire logic     RST,
  muldiv_unit_if.slave  bus
);
  import muldiv_unit_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  muldiv_op_t  r_op;
  logic [63:0] r_acc;
  word_t       r_opnd;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_divz;
  logic [4:0]  r_count;
  word_t       r_hi;
  word_t       r_lo;
  logic        r_busy;
  logic        r_done;

  logic        w_go;
  logic        w_last;
  logic        w_signed;
  logic        w_neg_prod;
  logic        w_neg_quo;
  logic        w_neg_rem;
  logic [63:0] w_step_acc;
  logic [63:0] w_fix_acc;
  word_t       w_abs_a;
  word_t       w_abs_b;

  assign w_go    = (r_state == S_IDLE) && bus.start && !bus.flush;
  assign w_last  = (r_count == 5'(MD_STEPS - 1));
  assign w_abs_a = abs_word(bus.srcA, op_is_signed(bus.op));
  assign w_abs_b = abs_word(bus.srcB, op_is_signed(bus.op));

  // ---------------- FSM ----------------
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_next = S_CALC;
      S_CALC:  if (bus.flush) w_next = S_IDLE;
               else if (w_last) w_next = S_FIXUP;
      S_FIXUP: w_next = bus.flush ? S_IDLE : S_DONE;
      // DONE always returns to IDLE; a start re-presented here is the same
      // stalled instruction and must not launch a second operation.
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- Datapath ----------------
  muldiv_step u_step (
    .i_is_div  (op_is_div(r_op)),
    .i_acc     (r_acc),
    .i_operand (r_opnd),
    .o_acc     (w_step_acc)
  );

  // Divide by zero leaves quo = all ones; skipping its negation keeps
  // lo = 0xFFFFFFFF, and negating rem = |A| by signA restores srcA as given.
  always_comb begin
    w_signed   = op_is_signed(r_op);
    w_neg_prod = w_signed && (r_sign_a ^ r_sign_b);
    w_neg_quo  = w_neg_prod && !r_divz;
    w_neg_rem  = w_signed && r_sign_a;
    if (op_is_div(r_op)) begin
      w_fix_acc[63:32] = w_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
      w_fix_acc[31:0]  = w_neg_quo ? (~r_acc[31:0]  + 32'd1) : r_acc[31:0];
    end else begin
      w_fix_acc = w_neg_prod ? (~r_acc + 64'd1) : r_acc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op     <= MD_MULT;
      r_acc    <= 64'd0;
      r_opnd   <= 32'd0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_divz   <= 1'b0;
      r_count  <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_go) begin
          // Both classes start from {0, |A|}: upper/multiplier or rem/quo.
          r_op     <= bus.op;
          r_acc    <= {32'd0, w_abs_a};
          r_opnd   <= w_abs_b;
          r_sign_a <= bus.srcA[31];
          r_sign_b <= bus.srcB[31];
          r_divz   <= (bus.srcB == 32'd0);
          r_count  <= 5'd0;
        end
        S_CALC: if (!bus.flush) begin
          r_acc <= w_step_acc;
          if (!w_last) r_count <= r_count + 5'd1;
        end
        S_FIXUP: if (!bus.flush) r_acc <= w_fix_acc;
        default: ;
      endcase
    end
  end

  // ---------------- HI/LO and status ----------------
  // Product and {rem, quo} share the layout hi = acc[63:32], lo = acc[31:0].
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_hi <= r_acc[63:32];
        r_lo <= r_acc[31:0];
      end else if (r_state == S_IDLE) begin
        if (bus.hi_wen) r_hi <= bus.wdat;
        if (bus.lo_wen) r_lo <= bus.wdat;
      end
    end
  end

  assign bus.stall = w_go || (r_state == S_CALC) || (r_state == S_FIXUP);
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: directed corner cases,
//               flush/reset aborts and randomized operations against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  muldiv_unit_if bus();

  muldiv_unit #(.MD_STEPS(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int    n_vec = 0;
  int    n_err = 0;
  word_t tb_hi = 32'd0;
  word_t tb_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input muldiv_op_t op, input word_t a, input word_t b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT:  begin p = 64'(sa * sb); return p; end
      MD_MULTU: begin p = {32'd0, a} * {32'd0, b}; return p; end
      MD_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Runs one operation with start held until after the DONE cycle, as a
  // stalled pipeline would. poke_k >= 1 asserts MTHI/MTLO during CALC.
  task automatic run_op(input muldiv_op_t op, input word_t a, input word_t b, input int poke_k);
    int stall_cnt = 0;
    int done_edge = -1;
    logic [63:0] exp;
    bus.start = 1'b1; bus.op = op; bus.srcA = a; bus.srcB = b;
    for (int k = 0; k < 60 && done_edge < 0; k++) begin
      bus.hi_wen = (k == poke_k); bus.lo_wen = (k == poke_k);
      bus.wdat   = (k == poke_k) ? 32'hDEAD_BEEF : 32'd0;
      #1;
      if (bus.stall) stall_cnt++;
      @(posedge CLK); #1;
      if (bus.done) done_edge = k;
    end
    bus.start = 1'b0; bus.hi_wen = 1'b0; bus.lo_wen = 1'b0;
    exp = model(op, a, b);
    check($sformatf("done_edge op%0d", op), 64'(done_edge), 64'd34);
    check($sformatf("stall_cycles op%0d", op), 64'(stall_cnt), 64'd34);
    check($sformatf("hi op%0d %h,%h", op, a, b), 64'(bus.hi), 64'(exp[63:32]));
    check($sformatf("lo op%0d %h,%h", op, a, b), 64'(bus.lo), 64'(exp[31:0]));
    tb_hi = exp[63:32]; tb_lo = exp[31:0];
    @(posedge CLK); #1;
    check("done_single_pulse", 64'(bus.done), 64'd0);
    check("busy_after_op", 64'(bus.busy), 64'd0);
  endtask

  function automatic word_t pick_operand();
    word_t corners [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0: return corners[$urandom_range(0, 4)];
      1: return word_t'($signed(32'($urandom_range(0, 200))) - 100);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int saw_done;
    bus.start = 1'b0; bus.op = MD_MULT; bus.srcA = 32'd0; bus.srcB = 32'd0;
    bus.flush = 1'b0; bus.hi_wen = 1'b0; bus.lo_wen = 1'b0; bus.wdat = 32'd0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);

    // start with flush in IDLE is ignored
    bus.start = 1'b1; bus.flush = 1'b1; #1;
    check("idle_flush_stall", 64'(bus.stall), 64'd0);
    @(posedge CLK); #1;
    check("idle_flush_busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b0; bus.flush = 1'b0;

    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd7, -1);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, -1);
    run_op(MD_DIVU,  32'd100, 32'd0, -1);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 12);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd0, -1);
    run_op(MD_DIVU,  32'hFFFF_FFFF, 32'h8000_0001, -1);

    // flush at CALC step 10
    bus.start = 1'b1; bus.op = MD_DIV; bus.srcA = 32'd1000; bus.srcB = 32'd3;
    for (int k = 0; k < 11; k++) begin
      if (k == 10) begin bus.flush = 1'b1; bus.start = 1'b0; end
      @(posedge CLK); #1;
    end
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_stall", 64'(bus.stall), 64'd0);
    bus.flush = 1'b0;
    saw_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (bus.done) saw_done = 1;
    end
    check("flush_no_done", 64'(saw_done), 64'd0);
    check("flush_hi_kept", 64'(bus.hi), 64'(tb_hi));
    check("flush_lo_kept", 64'(bus.lo), 64'(tb_lo));

    // reset at CALC step 5
    bus.start = 1'b1; bus.op = MD_MULT; bus.srcA = 32'd9; bus.srcB = 32'd9;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin RST = 1'b1; bus.start = 1'b0; end
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    check("mrst_busy", 64'(bus.busy), 64'd0);
    check("mrst_done", 64'(bus.done), 64'd0);
    check("mrst_stall", 64'(bus.stall), 64'd0);
    check("mrst_hi", 64'(bus.hi), 64'd0);
    check("mrst_lo", 64'(bus.lo), 64'd0);
    bus.hi_wen = 1'b1; bus.wdat = 32'h1234;
    @(posedge CLK); #1;
    bus.hi_wen = 1'b0; bus.lo_wen = 1'b1; bus.wdat = 32'h5678;
    check("mthi_hi", 64'(bus.hi), 64'h1234);
    check("mthi_lo", 64'(bus.lo), 64'd0);
    @(posedge CLK); #1;
    bus.lo_wen = 1'b0;
    check("mtlo_lo", 64'(bus.lo), 64'h5678);
    check("mtlo_hi", 64'(bus.hi), 64'h1234);

    // randomized operations
    for (int i = 0; i < 30; i++) begin
      muldiv_op_t rop;
      word_t ra, rb;
      rop = muldiv_op_t'($urandom_range(0, 3));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rop, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
